// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - runs wide ops through a shared 4-bit ALU one nibble per cycle, LSB first
// Optional abort input enabled by defining ALU_SEQ_ABORT_EN.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef ALU_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   start,
  input  logic [3:0]             op,
  input  logic [4*NIBBLES-1:0]   opa,
  input  logic [4*NIBBLES-1:0]   opb,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   zero,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_op,
  output logic                   alu_cin,
  input  logic [3:0]             alu_res,
  input  logic                   alu_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_SLT = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [IW+1:0]   lo;
  logic [3:0]      op_q;
  logic [W-1:0]    opa_q, opb_q, acc, merged, fin_res;
  logic            carry_reg, fin_c, lt, last, first, abort_hit;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign lo    = {idx, 2'b00};
  assign last  = (idx == IW'(NIBBLES - 1));
  assign first = (idx == '0);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_cin  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        if (abort_hit)  state_nx = S_IDLE;
        else if (last)  state_nx = S_DONE;
        alu_a = opa_q[lo +: 4];
        alu_b = opb_q[lo +: 4];
        // First nibble starts the chain; later nibbles consume the propagated carry/borrow.
        case (op_q)
          OP_ADD, OP_ADC: begin
            alu_op  = first ? OP_ADD : OP_ADC;
            alu_cin = carry_reg;
          end
          OP_SUB, OP_SBB, OP_SLT: begin
            alu_op  = first ? OP_SUB : OP_SBB;
            alu_cin = carry_reg;
          end
          default: alu_op = op_q;
        endcase
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    merged           = acc;
    merged[lo +: 4]  = alu_res;
    lt      = (opa_q[W-1] != opb_q[W-1]) ? opa_q[W-1] : alu_cout;
    fin_res = merged;
    fin_c   = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB: fin_c = alu_cout;
      OP_SLT:                         fin_res = {{(W-1){1'b0}}, lt};
      default:                        fin_res = merged;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q      <= op;
          opa_q     <= opa;
          opb_q     <= opb;
          idx       <= '0;
          acc       <= '0;
          carry_reg <= (op == OP_ADC || op == OP_SBB) ? cin : 1'b0;
        end
        S_RUN: begin
          acc       <= merged;
          carry_reg <= alu_cout;
          idx       <= idx + 1'b1;
          if (last && !abort_hit) begin
            result    <= fin_res;
            carry_out <= fin_c;
            zero      <= (fin_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - directed and random checks of alu_nibble_seq with a behavioural 4-bit ALU
module tb_alu_nibble_seq;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, start, cin, busy, done, carry_out, zero, alu_cin, alu_cout;
  logic [3:0]   op, alu_a, alu_b, alu_op, alu_res;
  logic [W-1:0] opa, opb, result;
`ifdef ALU_SEQ_ABORT_EN
  logic         abort;
`endif
  logic [4:0]   alu_t;
  int           pass_cnt = 0;
  int           total = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout)
  );

  // Shared 4-bit ALU: carry-in is always added/subtracted when set; unknown opcodes give 0.
  always_comb begin
    alu_t = '0;
    case (alu_op)
      4'd0, 4'd1: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
      4'd2, 4'd3: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - 5'(alu_cin);
      4'd4:       alu_t = {1'b0, alu_a & alu_b};
      4'd5:       alu_t = {1'b0, alu_a | alu_b};
      4'd6:       alu_t = {1'b0, alu_a ^ alu_b};
      default:    alu_t = '0;
    endcase
    alu_res  = alu_t[3:0];
    alu_cout = alu_t[4];
  end

  function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] a, b, input logic c);
    logic [W:0] sub;
    sub = {1'b0, b} + (W+1)'(c);
    case (o)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
      4'd2:    return {a < b, W'(a - b)};
      4'd3:    return {({1'b0, a} < sub), W'(a - b - W'(c))};
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, a | b};
      4'd6:    return {1'b0, a ^ b};
      4'd7:    return {1'b0, W'($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, b, input logic c,
                        input logic [W-1:0] exp_r, input logic exp_c);
    @(negedge clk);
    op = o; opa = a; opb = b; cin = c; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      if (k <= N) begin
        check("busy_run", busy, 1'b1);
        check("done_run", done, 1'b0);
        check("alu_a", alu_a, a[4*(k-1) +: 4]);
        check("alu_b", alu_b, b[4*(k-1) +: 4]);
        start = (k <= 2);
        op = 4'($urandom); opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom);
      end else begin
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b0);
        check("result", result, exp_r);
        check("carry_out", carry_out, exp_c);
        check("zero", zero, exp_r == '0);
      end
    end
    @(negedge clk);
    check("done_single", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("result_hold", result, exp_r);
  endtask

  task automatic run_rand();
    logic [3:0]   o;
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   m;
    o = 4'($urandom_range(0, 15));
    a = W'($urandom);
    b = W'($urandom);
    c = 1'($urandom);
    m = model(o, a, b, c);
    run_op(o, a, b, c, m[W-1:0], m[W]);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0);
    check("rst_carry", carry_out, 1'b0);
    check("rst_zero", zero, 1'b0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 13'h0);
    rst_n = 1'b1;

    run_op(4'd0, 16'h00FF, 16'h0001, 1'b1, 16'h0100, 1'b0);
    run_op(4'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    run_op(4'd3, 16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b0);
    run_op(4'd2, 16'h0005, 16'h0002, 1'b1, 16'h0003, 1'b0);
    run_op(4'd1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op(4'd7, 16'h8000, 16'h0001, 1'b0, 16'h0001, 1'b0);
    run_op(4'd7, 16'h0001, 16'h8000, 1'b0, 16'h0000, 1'b0);
    run_op(4'd7, 16'h0003, 16'h0007, 1'b1, 16'h0001, 1'b0);
    run_op(4'd6, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0);
    run_op(4'd9, 16'hABCD, 16'h1111, 1'b1, 16'h0000, 1'b0);
    run_op(4'd4, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0);

    // Reset while the third nibble is on the ALU.
    @(negedge clk);
    op = 4'd0; opa = 16'h1234; opb = 16'h5678; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_alu_a", alu_a, 4'h2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", result, 16'h0);
    check("mid_rst_flags", {busy, done, carry_out, zero}, 4'h0);
    check("mid_rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 13'h0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_rst", dones, 0);

`ifdef ALU_SEQ_ABORT_EN
    run_op(4'd5, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b0);
    @(negedge clk);
    op = 4'd0; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_hold", result, 16'h0FF0);
`endif

    for (int i = 0; i < 40; i++) run_rand();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
